// File: rtl/ecc_memory_scrubber_if.sv
// Host/memory bus bundle for ecc_memory_scrubber.
// slave  : scrubber view (accepts host requests, drives the memory port).
// master : environment view (host plus ecc_hamming_secded_faulty_memory).
interface ecc_memory_scrubber_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              host_corrected;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_corrected;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, mem_rdata, mem_corrected,
    output host_gnt, host_rdata, host_rvalid, host_corrected, mem_addr, mem_wdata, mem_wr_en
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, mem_rdata, mem_corrected,
    input  host_gnt, host_rdata, host_rvalid, host_corrected, mem_addr, mem_wdata, mem_wr_en
  );
endinterface

// File: rtl/ecc_memory_scrubber.sv
// ecc_memory_scrubber: host/scrub arbiter in front of an ECC SECDED memory.
// A background engine reads every address in turn and writes back any word the
// memory reports as corrected. Host requests always win while the engine is idle;
// a scrub read and its write-back are never split by a host access.
// Optional feature macro: SCRUB_ERR_LOG_EN (records address of latest scrub correction).
module ecc_memory_scrubber #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_memory_scrubber_if.slave  bus,
  input  logic                  scrub_enable,
  output logic                  scrub_busy,
  output logic                  pass_done,
  output logic [15:0]           corr_count,
  input  logic                  corr_clear,
  output logic [ADDR_W-1:0]     last_err_addr
);

  localparam int                CNT_W     = $clog2(SCRUB_INTERVAL);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCRUB_RD = 2'd1,
    SCRUB_WB = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [15:0]       corr_count_q, corr_count_d;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_corrected_q;
  logic              host_rvalid_q;

  logic              gnt;
  logic              due;
  logic              adv;
  logic              corr_inc;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              mem_wr_en_c;

  // FSM next state, interval counter, scrub address and memory port mux.
  // mem_wr_en and host_gnt are masked by rst so a write-back in flight when
  // reset arrives never reaches the memory.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    scrub_addr_d = scrub_addr_q;
    wb_data_d    = wb_data_q;
    gnt          = 1'b0;
    adv          = 1'b0;
    corr_inc     = 1'b0;
    mem_addr_c   = scrub_addr_q;
    mem_wdata_c  = '0;
    mem_wr_en_c  = 1'b0;
    due          = pend_q | (cnt_q == CNT_LAST);

    unique case (state_q)
      IDLE: begin
        gnt = bus.host_req & ~rst;
        if (gnt) begin
          mem_addr_c  = bus.host_addr;
          mem_wdata_c = bus.host_wdata;
          mem_wr_en_c = bus.host_we;
        end
        if (scrub_enable) begin
          if (due && !bus.host_req) begin
            state_d = SCRUB_RD;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else if (due) begin
            pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SCRUB_RD: begin
        if (bus.mem_corrected) begin
          state_d   = SCRUB_WB;
          wb_data_d = bus.mem_rdata;
        end else begin
          adv     = 1'b1;
          state_d = IDLE;
        end
      end
      SCRUB_WB: begin
        mem_wdata_c = wb_data_q;
        mem_wr_en_c = ~rst;
        corr_inc    = 1'b1;
        adv         = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!scrub_enable) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end

    if (adv) begin
      scrub_addr_d = (scrub_addr_q == ADDR_LAST) ? '0 : scrub_addr_q + 1'b1;
    end
  end

  // Saturating correction counter; a clear coinciding with a correction leaves 1.
  always_comb begin
    corr_count_d = corr_count_q;
    if (corr_clear) begin
      corr_count_d = corr_inc ? 16'd1 : '0;
    end else if (corr_inc && (corr_count_q != '1)) begin
      corr_count_d = corr_count_q + 16'd1;
    end
  end

  // Scrub engine state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      scrub_addr_q <= '0;
      wb_data_q    <= '0;
      corr_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      scrub_addr_q <= scrub_addr_d;
      wb_data_q    <= wb_data_d;
      corr_count_q <= corr_count_d;
    end
  end

  // Host read response capture, presented the cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata_q     <= '0;
      host_corrected_q <= 1'b0;
      host_rvalid_q    <= 1'b0;
    end else begin
      host_rvalid_q <= gnt & ~bus.host_we;
      if (gnt && !bus.host_we) begin
        host_rdata_q     <= bus.mem_rdata;
        host_corrected_q <= bus.mem_corrected;
      end
    end
  end

`ifdef SCRUB_ERR_LOG_EN
  logic [ADDR_W-1:0] last_err_q;
  logic              wb_enter;

  assign wb_enter = (state_q == SCRUB_RD) & bus.mem_corrected;

  // Address of the most recent scrub write-back; corr_clear leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_err_q <= '0;
    end else if (wb_enter) begin
      last_err_q <= scrub_addr_q;
    end
  end

  assign last_err_addr = last_err_q;
`else
  assign last_err_addr = '0;
`endif

  assign bus.host_gnt       = gnt;
  assign bus.host_rdata     = host_rdata_q;
  assign bus.host_rvalid    = host_rvalid_q;
  assign bus.host_corrected = host_corrected_q;
  assign bus.mem_addr       = mem_addr_c;
  assign bus.mem_wdata      = mem_wdata_c;
  assign bus.mem_wr_en      = mem_wr_en_c;

  assign scrub_busy = (state_q != IDLE);
  assign pass_done  = adv & (scrub_addr_q == ADDR_LAST) & ~rst;
  assign corr_count = corr_count_q;

endmodule

// File: tb/tb_ecc_memory_scrubber.sv
// Directed bench for ecc_memory_scrubber with a small behavioural ECC memory:
// stored words read back clean, a planted fault only raises the corrected flag
// until the faulty address is rewritten.
module tb_ecc_memory_scrubber;

  logic        clk = 1'b0;
  logic        rst;
  logic        scrub_enable;
  logic        scrub_busy;
  logic        pass_done;
  logic [15:0] corr_count;
  logic        corr_clear;
  logic [3:0]  last_err_addr;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16] = '{default: 8'h00};
  logic       fault_valid = 1'b0;
  logic [3:0] fault_addr  = 4'd0;
  logic       inject = 1'b0;
  logic [3:0] inject_addr = 4'd0;

  ecc_memory_scrubber_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  ecc_memory_scrubber #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(16), .SCRUB_INTERVAL(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .scrub_enable(scrub_enable), .scrub_busy(scrub_busy), .pass_done(pass_done),
    .corr_count(corr_count), .corr_clear(corr_clear), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata     = mem[bus.mem_addr];
  assign bus.mem_corrected = fault_valid && (fault_addr == bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (inject) begin
      fault_valid <= 1'b1;
      fault_addr  <= inject_addr;
    end else if (bus.mem_wr_en && bus.mem_addr == fault_addr) begin
      fault_valid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plant(input logic [3:0] a);
    inject_addr = a;
    inject = 1'b1;
    step();
    inject = 1'b0;
  endtask

  // Returns at the first cycle the engine is in write-back, or after the budget.
  task automatic wait_wb(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (scrub_busy && bus.mem_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pass(output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      cycles++;
      if (pass_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         seen;
    int         cyc;
    int         wb_cnt;
    logic [3:0] wb_addr;
    logic [7:0] wb_data;

    rst = 1'b1;
    scrub_enable = 1'b0;
    corr_clear = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_rvalid", bus.host_rvalid, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    chk("rst_corr", corr_count, 0);
    chk("rst_busy", scrub_busy, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_last_err", last_err_addr, 0);

    // 1: write then read addr 3
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd3; bus.host_wdata = 8'hA5;
    #1;
    chk("t1_wr_gnt", bus.host_gnt, 1);
    chk("t1_wr_en", bus.mem_wr_en, 1);
    chk("t1_wr_addr", bus.mem_addr, 3);
    chk("t1_wr_data", bus.mem_wdata, 8'hA5);
    step();
    bus.host_we = 1'b0;
    #1;
    chk("t1_rd_gnt", bus.host_gnt, 1);
    chk("t1_rd_wr_en", bus.mem_wr_en, 0);
    step();
    bus.host_req = 1'b0;
    chk("t1_rvalid", bus.host_rvalid, 1);
    chk("t1_rdata", bus.host_rdata, 8'hA5);
    chk("t1_corrected", bus.host_corrected, 0);
    step();
    chk("t1_rvalid_pulse", bus.host_rvalid, 0);

    // 2: fill, plant fault at 5, host read does not repair it, one scrub pass does
    for (int i = 0; i < 16; i++) begin
      bus.host_req = 1'b1; bus.host_we = 1'b1;
      bus.host_addr = 4'(i); bus.host_wdata = 8'(8'h10 + i);
      step();
    end
    bus.host_req = 1'b0;
    plant(4'd5);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd5;
    step();
    bus.host_req = 1'b0;
    chk("t2_host_rdata", bus.host_rdata, 8'h15);
    chk("t2_host_corr", bus.host_corrected, 1);
    step();
    chk("t2_no_host_wb", fault_valid, 1);
    scrub_enable = 1'b1;
    wb_cnt = 0; wb_addr = '0; wb_data = '0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (scrub_busy && bus.mem_wr_en) begin
        wb_cnt++;
        wb_addr = bus.mem_addr;
        wb_data = bus.mem_wdata;
      end
      if (pass_done) begin
        seen = 1'b1;
        break;
      end
    end
    scrub_enable = 1'b0;
    chk("t2_pass_seen", seen, 1);
    step();
    chk("t2_wb_count", wb_cnt, 1);
    chk("t2_wb_addr", wb_addr, 5);
    chk("t2_wb_data", wb_data, 8'h15);
    chk("t2_corr_count", corr_count, 1);
    chk("t2_fault_gone", fault_valid, 0);
`ifdef SCRUB_ERR_LOG_EN
    chk("t2_last_err", last_err_addr, 5);
`else
    chk("t2_last_err", last_err_addr, 0);
`endif
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd5;
    step();
    bus.host_req = 1'b0;
    chk("t2_reread_data", bus.host_rdata, 8'h15);
    chk("t2_reread_corr", bus.host_corrected, 0);

    // 3: fault-free pass period with interval 4 is 16*5 cycles
    corr_clear = 1'b1;
    step();
    corr_clear = 1'b0;
    chk("t3_clear", corr_count, 0);
    scrub_enable = 1'b1;
    wait_pass(seen, cyc);
    chk("t3_first_pass", seen, 1);
    wait_pass(seen, cyc);
    chk("t3_second_pass", seen, 1);
    chk("t3_period", cyc, 80);
    chk("t3_corr_count", corr_count, 0);

    // 4: host held through scrub due point, then a request during SCRUB_RD
    for (int i = 0; i < 6; i++) begin
      step();
      bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd2;
      #1;
      if (i == 0) chk("t4_pass_pulse", pass_done, 0);
      chk("t4_held_gnt", bus.host_gnt, 1);
      chk("t4_held_busy", scrub_busy, 0);
    end
    step();
    bus.host_req = 1'b0;
    chk("t4_idle_busy", scrub_busy, 0);
    step();
    bus.host_req = 1'b1;
    #1;
    chk("t4_rd_busy", scrub_busy, 1);
    chk("t4_rd_addr", bus.mem_addr, 0);
    chk("t4_rd_gnt", bus.host_gnt, 0);
    step();
    chk("t4_after_gnt", bus.host_gnt, 1);
    chk("t4_after_busy", scrub_busy, 0);
    bus.host_req = 1'b0;
    scrub_enable = 1'b0;

    // 5: saturation, then clear coinciding with a correction
    step();
    force dut.corr_count_q = 16'hFFFF;
    step();
    release dut.corr_count_q;
    step();
    chk("t5_forced", corr_count, 16'hFFFF);
    plant(4'd7);
    scrub_enable = 1'b1;
    wait_wb(seen);
    chk("t5_wb_seen", seen, 1);
    chk("t5_wb_addr", bus.mem_addr, 7);
    chk("t5_wb_data", bus.mem_wdata, 8'h17);
    step();
    chk("t5_saturated", corr_count, 16'hFFFF);
    plant(4'd9);
    wait_wb(seen);
    chk("t5_wb2_seen", seen, 1);
    chk("t5_wb2_addr", bus.mem_addr, 9);
    corr_clear = 1'b1;
    step();
    corr_clear = 1'b0;
    scrub_enable = 1'b0;
    chk("t5_clear_inc", corr_count, 1);
`ifdef SCRUB_ERR_LOG_EN
    chk("t5_last_err", last_err_addr, 9);
`endif
    corr_clear = 1'b1;
    step();
    corr_clear = 1'b0;
    chk("t5_clear_only", corr_count, 0);

    // 6: reset during write-back drops the write
    plant(4'd11);
    scrub_enable = 1'b1;
    wait_wb(seen);
    chk("t6_wb_seen", seen, 1);
    rst = 1'b1;
    #1;
    chk("t6_wr_masked", bus.mem_wr_en, 0);
    step();
    rst = 1'b0;
    scrub_enable = 1'b0;
    #1;
    chk("t6_busy", scrub_busy, 0);
    chk("t6_wr_en", bus.mem_wr_en, 0);
    chk("t6_scrub_addr", bus.mem_addr, 0);
    chk("t6_corr", corr_count, 0);
    chk("t6_last_err", last_err_addr, 0);
    chk("t6_fault_kept", fault_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
